// File: rtl/des_dec_key_sched_pkg.sv
// +--------------------------------------------------------------------+
// | des_ks_pkg : DES key-schedule tables, widths, state type, rotator  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package des_ks_pkg;

  localparam int KEY_W  = 64;
  localparam int CD_W   = 56;
  localparam int HALF_W = 28;
  localparam int RK_W   = 48;
  localparam int IDX_W  = 4;

  // Entries are DES bit numbers (1 = MSB of the source vector).
  localparam int PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [RK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Forward left-shift schedule, indexed by round number minus 1.
  localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_e;

  // Undoes the forward shift of round idx+1: right rotate, DES bit 28 wraps to bit 1.
  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] v,
                                               input logic [IDX_W-1:0]  idx);
    logic [HALF_W-1:0] r;
    if (SHIFT_TAB[idx] == 2) r = {v[1:0], v[HALF_W-1:2]};
    else                     r = {v[0], v[HALF_W-1:1]};
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/des_dec_key_sched_if.sv
// +--------------------------------------------------------------------+
// | des_dec_key_sched_if : key input and round-key output streams      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface des_dec_key_sched_if;
  import des_ks_pkg::*;

  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key;
  logic             rkey_valid;
  logic             rkey_ready;
  logic [RK_W-1:0]  rkey;
  logic [IDX_W-1:0] rkey_idx;
  logic             rkey_last;
  logic             parity_err;

  modport master (
    output key_valid, key, rkey_ready,
    input  key_ready, rkey_valid, rkey, rkey_idx, rkey_last, parity_err
  );

  modport slave (
    input  key_valid, key, rkey_ready,
    output key_ready, rkey_valid, rkey, rkey_idx, rkey_last, parity_err
  );

endinterface

`default_nettype wire

// File: rtl/des_dec_key_sched_pc2.sv
// +--------------------------------------------------------------------+
// | des_pc2 : combinational DES PC-2 permutation, 56 -> 48 bits        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module des_pc2
  import des_ks_pkg::*;
(
  input  logic [CD_W-1:0] i_cd,
  output logic [RK_W-1:0] o_rk
);

  for (genvar i = 0; i < RK_W; i++) begin : g_pc2
    assign o_rk[RK_W-1-i] = i_cd[CD_W-PC2_TAB[i]];
  end

endmodule

`default_nettype wire

// File: rtl/des_dec_key_sched.sv
// +--------------------------------------------------------------------+
// | des_dec_key_sched : DES decrypt round keys K16..K1, one per beat.  |
// | Optional byte parity check on keys: DES_KEY_PARITY_CHK_EN.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module des_dec_key_sched
  import des_ks_pkg::*;
#(
  parameter bit ZEROIZE = 1'b1
)
(
  input  logic               clk,
  input  logic               rst_n,
  des_dec_key_sched_if.slave ks
);

  ks_state_e         r_state;
  logic [HALF_W-1:0] r_c;
  logic [HALF_W-1:0] r_d;
  logic [IDX_W-1:0]  r_idx;
  logic              r_key_ready;
  logic              r_rkey_valid;
  logic              r_rkey_last;
  logic              r_parity_err;

  logic [CD_W-1:0]   w_pc1;
  logic [HALF_W-1:0] w_c_rot;
  logic [HALF_W-1:0] w_d_rot;
  logic              w_key_ok;

  for (genvar i = 0; i < CD_W; i++) begin : g_pc1
    assign w_pc1[CD_W-1-i] = ks.key[KEY_W-PC1_TAB[i]];
  end

`ifdef DES_KEY_PARITY_CHK_EN
  logic [7:0] w_byte_odd;
  for (genvar b = 0; b < 8; b++) begin : g_par
    assign w_byte_odd[b] = ^ks.key[8*b +: 8];
  end
  assign w_key_ok = &w_byte_odd;
`else
  assign w_key_ok = 1'b1;
`endif

  assign w_c_rot = rotr28(r_c, r_idx);
  assign w_d_rot = rotr28(r_d, r_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_c          <= '0;
      r_d          <= '0;
      r_idx        <= '0;
      r_key_ready  <= 1'b1;
      r_rkey_valid <= 1'b0;
      r_rkey_last  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ks.key_valid && r_key_ready) begin
            if (w_key_ok) begin
              // K16 equals the unrotated PC-1 output: the forward shifts total 28.
              r_c          <= w_pc1[CD_W-1:HALF_W];
              r_d          <= w_pc1[HALF_W-1:0];
              r_idx        <= {IDX_W{1'b1}};
              r_state      <= RUN;
              r_key_ready  <= 1'b0;
              r_rkey_valid <= 1'b1;
              r_rkey_last  <= 1'b0;
            end else begin
              r_parity_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ks.rkey_ready) begin
            if (r_idx == '0) begin
              r_state      <= IDLE;
              r_key_ready  <= 1'b1;
              r_rkey_valid <= 1'b0;
              r_rkey_last  <= 1'b0;
              if (ZEROIZE) begin
                r_c <= '0;
                r_d <= '0;
              end
            end else begin
              r_c         <= w_c_rot;
              r_d         <= w_d_rot;
              r_idx       <= r_idx - 1'b1;
              r_rkey_last <= (r_idx == IDX_W'(1));
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_key_ready  <= 1'b1;
          r_rkey_valid <= 1'b0;
          r_rkey_last  <= 1'b0;
        end
      endcase
    end
  end

  des_pc2 u_pc2 (
    .i_cd ({r_c, r_d}),
    .o_rk (ks.rkey)
  );

  assign ks.key_ready  = r_key_ready;
  assign ks.rkey_valid = r_rkey_valid;
  assign ks.rkey_idx   = r_idx;
  assign ks.rkey_last  = r_rkey_last;
  assign ks.parity_err = r_parity_err;

endmodule

`default_nettype wire

// File: doc/des_dec_key_sched.md
Name: des_dec_key_sched

Overview:
- Sequential DES round-key generator for the decryption datapath.
- Accepts one 64-bit key, applies PC-1, and emits the 16 round keys in reverse order (K16 first, K1 last), one per accepted transfer.
- Walks C/D right-rotation by the inverse shift schedule, so only one 56-bit state and one PC-2 instance are needed.
- Feeds the round engine of the DES decrypt core through a valid/ready stream.

Parameters:
- ZEROIZE, 1: when 1, the C/D state register is cleared to 0 after K1 is accepted; when 0, it holds its last value.

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- KEY_VALID  in  1  KEY is valid this cycle
- KEY_READY  out  1  block can accept a key (high only in IDLE)
- KEY  in  64  DES key; DES bit 1 = KEY[63], parity bits included
- RKEY_VALID  out  1  RKEY/RKEY_IDX are valid
- RKEY_READY  in  1  consumer accepts the current round key
- RKEY  out  48  PC-2(C,D); DES bit 1 = RKEY[47]
- RKEY_IDX  out  4  round number minus 1 (15 = K16 ... 0 = K1)
- RKEY_LAST  out  1  high with RKEY_VALID when RKEY_IDX==0
- PARITY_ERR  out  1  one-cycle pulse on a parity-failing key; tied 0 unless the macro is defined

Behaviour:
- Reset (async, RST_N=0): state=IDLE; C,D=0; idx=0; RKEY_VALID=0, RKEY_LAST=0, PARITY_ERR=0; RKEY=PC-2(0)=0; KEY_READY=1 after reset release.
- States are IDLE and RUN.
- IDLE:
  - KEY_READY=1.
  - On KEY_VALID&KEY_READY at edge N: {C,D}<=PC-1(KEY), idx<=15, go to RUN.
  - KEY_VALID while not ready is ignored; the key is not captured.
- RUN:
  - KEY_READY=0; RKEY_VALID=1; RKEY=PC-2({C,D}) combinationally from registered state.
  - RKEY and RKEY_IDX are stable while RKEY_VALID&!RKEY_READY.
  - On RKEY_READY with idx!=0: C<=rotr28(C,S[idx]), D<=rotr28(D,S[idx]), idx<=idx-1.
  - On RKEY_READY with idx==0: go to IDLE; if ZEROIZE, C,D<=0.
- Shift table S[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (forward schedule, round-indexed).
  - K16 uses PC-1 output unrotated, because the forward total is 28 (identity).
- Latency:
  - Key accepted at edge N gives RKEY_VALID high from cycle N+1.
  - With RKEY_READY held high, K16..K1 appear in cycles N+1..N+16 and KEY_READY returns in cycle N+17.
- Rotation is modulo 28 on each half independently; wrap bit 28 goes into bit 1 (DES numbering).
- Backpressure may stall any number of cycles at any idx with no state change.
- Reset asserted mid-run aborts immediately; no partial keys follow after release.
- KEY_VALID during RUN is ignored; no queueing.

Optional Feature:
- Macro: DES_KEY_PARITY_CHK_EN.
- Defined:
  - Each KEY byte must have odd parity.
  - On acceptance of a failing key: PARITY_ERR=1 for cycle N+1, state stays IDLE, no round keys are emitted, C/D are unchanged.
  - A passing key behaves as above.
- Undefined: no check is performed; PARITY_ERR is constant 0.

Decomposition:
- Package des_ks_pkg holds:
  - PC-1 table (56 entries) and PC-2 table (48 entries) as constants.
  - Shift table S.
  - State enum {IDLE, RUN}.
  - Width constants (KEY_W=64, CD_W=56, RK_W=48, IDX_W=4).
- One sub-module, des_pc2: purely combinational 56->48 PC-2 permutation driven from the package table.
- PC-1 and rotations stay inline.

Test Plan:
- Known-answer: KEY=0x133457799BBCDFF1, RKEY_READY=1 -> first RKEY=0xCB3D8B0E17F5 (IDX 15); 15th=0x79AED9DBC9E5 (IDX 1); 16th=0x1B02EFFC7072 (IDX 0, LAST=1); KEY_READY at N+17.
- Backpressure: same key, RKEY_READY low for 5 cycles at IDX 8 and randomly elsewhere -> RKEY/IDX stable while stalled; the sequence of 16 keys is identical to the known-answer test.
- Reset mid-run: assert RST_N=0 at IDX 7 -> RKEY_VALID=0 immediately; after release, KEY_READY=1 and a new key yields a correct full sequence from IDX 15.
- Key ignored while busy: pulse KEY_VALID with 0xFFFFFFFFFFFFFFFF during RUN -> no effect on the outputs; ZEROIZE=1 -> internal C/D==0 after LAST is accepted.
- Parity (macro defined): KEY=0x133457799BBCDFF0 -> PARITY_ERR pulse at N+1, RKEY_VALID stays 0, KEY_READY=1. Macro undefined: the same key produces 16 keys and PARITY_ERR=0.
- Back-to-back: a second key presented in the cycle KEY_READY rises -> accepted; first RKEY appears exactly one cycle later.
